// File: rtl/adder_mon_pkg.sv
// Shared types and defaults for the approximate-adder error monitor and the
// generated adder wrappers.
package adder_mon_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } mon_state_t;

    localparam int unsigned DEF_W      = 4;
    localparam int unsigned DEF_CW     = 16;
    localparam int unsigned DEF_ET     = 14;
    localparam int unsigned DEF_WINDOW = 256;

    // Sum/error width and accumulated-error width for the default operand size
    localparam int unsigned SW  = DEF_W + 1;
    localparam int unsigned ESW = DEF_CW + DEF_W + 1;

endpackage

// File: rtl/abs_err_calc.sv
// Combinational exact sum, absolute error against the approximate sum, and
// threshold violation flag.
module abs_err_calc #(
    parameter int unsigned W  = 4,
    parameter int unsigned ET = 14
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W:0]   approx,
    output logic [W:0]   err,
    output logic         viol
);

    logic [W:0]          exact;
    logic signed [W+1:0] diff;

    assign exact = {1'b0, a} + {1'b0, b};
    assign diff  = $signed({1'b0, exact}) - $signed({1'b0, approx});

    // |diff| always fits in W+1 bits, so negate only the low bits
    assign err  = diff[W+1] ? (~diff[W:0] + 1'b1) : diff[W:0];
    assign viol = (32'(err) > 32'(ET));

endmodule

// File: rtl/adder_err_monitor.sv
// Windowed error-statistics monitor for an approximate adder: valid/ready
// sample intake, two-stage recompute/accumulate pipeline, run/drain FSM.
module adder_err_monitor
    import adder_mon_pkg::*;
#(
    parameter int unsigned W      = DEF_W,
    parameter int unsigned ET     = DEF_ET,
    parameter int unsigned WINDOW = DEF_WINDOW,
    parameter int unsigned CW     = DEF_CW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_a,
    input  logic [W-1:0]      in_b,
    input  logic [W:0]        in_approx,
    output logic              busy,
    output logic              done,
    output logic [CW-1:0]     sample_cnt,
    output logic [W:0]        err_max,
    output logic [CW+W:0]     err_sum,
    output logic [CW-1:0]     viol_cnt,
    output logic              viol_seen
);

    localparam logic [CW-1:0] WIN_L  = CW'(WINDOW);
    localparam logic [CW-1:0] LAST_L = CW'(WINDOW - 1);

    mon_state_t    state, state_nxt;
    logic [CW-1:0] acc_cnt;
    logic          xfer;
    logic          open_win;

    logic [W:0]    calc_err;
    logic          calc_viol;

    logic          s1_valid;
    logic [W:0]    s1_err;
    logic          s1_viol;

    assign in_ready = (state == RUN) && (acc_cnt < WIN_L);
    assign xfer     = in_valid && in_ready;
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);
    assign open_win = start && ((state == IDLE) || (state == DONE));

    abs_err_calc #(
        .W  (W),
        .ET (ET)
    ) u_calc (
        .a      (in_a),
        .b      (in_b),
        .approx (in_approx),
        .err    (calc_err),
        .viol   (calc_viol)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // The input transfer and S1 valid are the two pipeline stages that must
    // be empty before DONE; S2 commits on the edge that consumes S1.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (xfer && (acc_cnt == LAST_L)) state_nxt = DRAIN;
            DRAIN:   if (!xfer && !s1_valid) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt    <= '0;
            s1_valid   <= 1'b0;
            s1_err     <= '0;
            s1_viol    <= 1'b0;
            sample_cnt <= '0;
            err_max    <= '0;
            err_sum    <= '0;
            viol_cnt   <= '0;
            viol_seen  <= 1'b0;
        end else begin
            s1_valid <= xfer;
            if (xfer) begin
                s1_err  <= calc_err;
                s1_viol <= calc_viol;
                acc_cnt <= acc_cnt + 1'b1;
            end

            if (open_win) begin
                acc_cnt    <= '0;
                s1_valid   <= 1'b0;
                sample_cnt <= '0;
                err_max    <= '0;
                err_sum    <= '0;
                viol_cnt   <= '0;
                viol_seen  <= 1'b0;
            end else if (s1_valid) begin
                sample_cnt <= sample_cnt + 1'b1;
                err_sum    <= err_sum + {{CW{1'b0}}, s1_err};
                if (s1_err > err_max) err_max <= s1_err;
                viol_cnt   <= viol_cnt + CW'(s1_viol);
                viol_seen  <= viol_seen | s1_viol;
            end
        end
    end

endmodule

// File: tb/tb_adder_err_monitor.sv
// Directed self-checking bench for adder_err_monitor (W=4, ET=14, WINDOW=4).
module tb_adder_err_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic [4:0]  in_approx;
    logic        busy;
    logic        done;
    logic [15:0] sample_cnt;
    logic [4:0]  err_max;
    logic [20:0] err_sum;
    logic [15:0] viol_cnt;
    logic        viol_seen;

    int tests_run    = 0;
    int tests_failed = 0;

    adder_err_monitor #(
        .W      (4),
        .ET     (14),
        .WINDOW (4),
        .CW     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_approx  (in_approx),
        .busy       (busy),
        .done       (done),
        .sample_cnt (sample_cnt),
        .err_max    (err_max),
        .err_sum    (err_sum),
        .viol_cnt   (viol_cnt),
        .viol_seen  (viol_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_stats(input string tag, input int cnt, input int emax,
                                input int esum, input int vcnt, input int vseen);
        check({tag, "_cnt"},   32'(sample_cnt), 32'(cnt));
        check({tag, "_max"},   32'(err_max),    32'(emax));
        check({tag, "_sum"},   32'(err_sum),    32'(esum));
        check({tag, "_viol"},  32'(viol_cnt),   32'(vcnt));
        check({tag, "_seen"},  32'(viol_seen),  32'(vseen));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Presents one sample and returns 1 ns after the edge that accepted it.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [4:0] s);
        int guard = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_approx = s;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("send_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done();
        int guard = 0;
        @(negedge clk);
        while (!done && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_approx = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(done),     32'd0);
        expect_stats("rst", 0, 0, 0, 0, 0);
        rst = 1'b0;

        // exact stream with done-latency checks
        pulse_start();
        check("run_ready", 32'(in_ready), 32'd1);
        check("run_busy",  32'(busy),     32'd1);
        send(4'd3,  4'd5,  5'd8);
        send(4'd0,  4'd0,  5'd0);
        send(4'd15, 4'd15, 5'd30);
        send(4'd7,  4'd1,  5'd8);
        @(negedge clk);
        check("drain_busy",  32'(busy),     32'd1);
        check("drain_ready", 32'(in_ready), 32'd0);
        check("drain_done0", 32'(done),     32'd0);
        @(negedge clk);
        check("drain_done1", 32'(done),     32'd0);
        @(negedge clk);
        check("done_hi",   32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        expect_stats("exact", 4, 0, 0, 0, 0);

        // restart from DONE, then threshold-edge stream
        pulse_start();
        check("restart_done",  32'(done),     32'd0);
        check("restart_ready", 32'(in_ready), 32'd1);
        expect_stats("restart", 0, 0, 0, 0, 0);
        send(4'd15, 4'd15, 5'd16);
        @(negedge clk);
        check("lat_cnt_before", 32'(sample_cnt), 32'd0);
        @(posedge clk);
        #1;
        check("lat_cnt_after", 32'(sample_cnt), 32'd1);
        check("lat_max14",     32'(err_max),    32'd14);
        check("lat_noviol",    32'(viol_seen),  32'd0);
        send(4'd15, 4'd15, 5'd15);
        pulse_start();
        check("start_in_run_busy", 32'(busy), 32'd1);
        send(4'd0, 4'd0, 5'd31);
        send(4'd8, 4'd8, 5'd16);
        wait_done();
        expect_stats("thresh", 4, 31, 60, 2, 1);

        // gaps on in_valid and extra samples offered after the window fills
        pulse_start();
        idle($urandom_range(0, 3));
        send(4'd1, 4'd2, 5'd3);
        idle($urandom_range(0, 3));
        send(4'd9, 4'd9, 5'd2);
        idle($urandom_range(0, 3));
        send(4'd4, 4'd4, 5'd0);
        idle($urandom_range(0, 3));
        send(4'd6, 4'd7, 5'd20);
        @(negedge clk);
        in_valid = 1'b1; in_a = 4'd15; in_b = 4'd15; in_approx = 5'd0;
        check("bp_drain_ready", 32'(in_ready), 32'd0);
        wait_done();
        check("bp_done_ready", 32'(in_ready), 32'd0);
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        expect_stats("bp", 4, 16, 31, 1, 1);

        // reset mid-window with a sample still in S1
        pulse_start();
        send(4'd15, 4'd15, 5'd0);
        send(4'd1,  4'd1,  5'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_busy",  32'(busy),     32'd0);
        check("mrst_done",  32'(done),     32'd0);
        check("mrst_ready", 32'(in_ready), 32'd0);
        expect_stats("mrst", 0, 0, 0, 0, 0);
        rst = 1'b0;
        idle(3);
        check("mrst_late_cnt", 32'(sample_cnt), 32'd0);
        check("mrst_late_sum", 32'(err_sum),    32'd0);
        check("mrst_idle",     32'(busy),       32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
